// File: rtl/ir_nec_rx_1506.sv
// NEC infrared frame decoder with an Avalon-MM register slave.
// The raw receiver pin is synchronized and filtered, and then timed in microsecond ticks.
// Each pulse width is classified, and a 32-bit LSB-first frame is assembled and validated.
// TIME_DIV scales every protocol window down for fast simulation. It is 1 for real NEC timing.
module ir_nec_rx_1506 #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned TIMEOUT_US  = 12000,
  parameter int unsigned TIME_DIV    = 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        coe_ir_in,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        ins_irq
);

  localparam int unsigned TickDiv = CLK_FREQ_HZ / 1000000;
  localparam logic [15:0] TickMax = 16'(TickDiv - 1);

  localparam logic [15:0] LeadLMin = 16'(8000 / TIME_DIV);
  localparam logic [15:0] LeadLMax = 16'(10000 / TIME_DIV);
  localparam logic [15:0] LeadHMin = 16'(4000 / TIME_DIV);
  localparam logic [15:0] LeadHMax = 16'(5000 / TIME_DIV);
  localparam logic [15:0] RepHMin  = 16'(2000 / TIME_DIV);
  localparam logic [15:0] RepHMax  = 16'(2500 / TIME_DIV);
  localparam logic [15:0] ShortMin = 16'(400 / TIME_DIV);
  localparam logic [15:0] ShortMax = 16'(700 / TIME_DIV);
  localparam logic [15:0] LongMin  = 16'(1400 / TIME_DIV);
  localparam logic [15:0] LongMax  = 16'(1900 / TIME_DIV);
  localparam logic [15:0] TimeoutW = 16'(TIMEOUT_US);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLeadL  = 3'd1,
    StLeadH  = 3'd2,
    StBitL   = 3'd3,
    StBitH   = 3'd4,
    StDone   = 3'd5,
    StRepeat = 3'd6
  } state_e;

  function automatic logic in_rng(input logic [15:0] v, input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Input conditioning and timing state.
  logic [1:0]  sync_q, sync_d;
  logic [15:0] presc_q, presc_d;
  logic [2:0]  win_q, win_d;
  logic        flt_q, flt_d;
  logic [15:0] us_cnt_q, us_cnt_d;
  logic        tick, fall, rise;

  // Decoder state.
  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        frame_done, rep_evt, frame_ok;

  // Register file.
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        rep_q, rep_d;
  logic        ovr_q, ovr_d;
  logic        err_q, err_d;
  logic        seen_q, seen_d;
  logic        irq_en_q, irq_en_d;
  logic        chk_en_q, chk_en_d;
  logic        rd_clr_q, rd_clr_d;
  logic [31:0] readdata_q, readdata_d;
  logic        irq_q, irq_d;
  logic [3:0]  w1c;
  logic        unused_wd;

  assign unused_wd = ^avs_writedata[31:4];

  assign tick = (presc_q == TickMax);

  // Prescaler, glitch filter and microsecond width counter.
  always_comb begin
    sync_d  = {sync_q[0], coe_ir_in};
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    win_d   = win_q;
    flt_d   = flt_q;
    if (tick) begin
      win_d = {win_q[1:0], sync_q[1]};
      // Filtered level only moves after three agreeing samples, so pulses under 3 us vanish.
      if (win_d == 3'b000) begin
        flt_d = 1'b0;
      end else if (win_d == 3'b111) begin
        flt_d = 1'b1;
      end
    end
    fall = flt_q & ~flt_d;
    rise = ~flt_q & flt_d;
    us_cnt_d = us_cnt_q;
    if (fall || rise) begin
      us_cnt_d = 16'd0;
    end else if (tick && (us_cnt_q != 16'hFFFF)) begin
      us_cnt_d = us_cnt_q + 16'd1;
    end
  end

  // Conditioning registers; the line idles high.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q   <= 2'b11;
      presc_q  <= 16'd0;
      win_q    <= 3'b111;
      flt_q    <= 1'b1;
      us_cnt_q <= 16'd0;
    end else begin
      sync_q   <= sync_d;
      presc_q  <= presc_d;
      win_q    <= win_d;
      flt_q    <= flt_d;
      us_cnt_q <= us_cnt_d;
    end
  end

  // Frame decoder next state: widths are judged at the edge that ends each period.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    frame_done = 1'b0;
    rep_evt    = 1'b0;
    if ((state_q != StIdle) && (us_cnt_q >= TimeoutW)) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (fall) state_d = StLeadL;
        end
        StLeadL: begin
          if (rise) state_d = in_rng(us_cnt_q, LeadLMin, LeadLMax) ? StLeadH : StIdle;
        end
        StLeadH: begin
          if (fall) begin
            if (in_rng(us_cnt_q, LeadHMin, LeadHMax)) begin
              state_d   = StBitL;
              bit_cnt_d = 5'd0;
            end else if (in_rng(us_cnt_q, RepHMin, RepHMax)) begin
              state_d = StRepeat;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StBitL: begin
          if (rise) state_d = in_rng(us_cnt_q, ShortMin, ShortMax) ? StBitH : StIdle;
        end
        StBitH: begin
          if (fall) begin
            if (in_rng(us_cnt_q, ShortMin, ShortMax) || in_rng(us_cnt_q, LongMin, LongMax)) begin
              shreg_d = {in_rng(us_cnt_q, LongMin, LongMax), shreg_q[31:1]};
              if (bit_cnt_q == 5'd31) begin
                state_d = StDone;
              end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                state_d   = StBitL;
              end
            end else begin
              state_d = StIdle;
            end
          end
        end
        StDone: begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end
        StRepeat: begin
          rep_evt = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Decoder registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= 5'd0;
      shreg_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  assign frame_ok = !(chk_en_q && ((shreg_q[7:0] != ~shreg_q[15:8]) ||
                                   (shreg_q[23:16] != ~shreg_q[31:24])));

  // Status, control and bus read path; decoder sets override same-cycle clears.
  always_comb begin
    w1c = (avs_write && (avs_address == 2'd1)) ? avs_writedata[3:0] : 4'd0;
    data_d   = data_q;
    seen_d   = seen_q;
    valid_d  = valid_q & ~w1c[0] & ~rd_clr_q;
    rep_d    = rep_q & ~w1c[1] & ~rd_clr_q;
    ovr_d    = ovr_q & ~w1c[2];
    err_d    = err_q & ~w1c[3];
    irq_en_d = irq_en_q;
    chk_en_d = chk_en_q;
    if (frame_done) begin
      if (frame_ok) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
        rep_d   = 1'b0;
        seen_d  = 1'b1;
        if (valid_q) ovr_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (rep_evt && (valid_q || seen_q)) rep_d = 1'b1;
    if (avs_write && (avs_address == 2'd2)) begin
      irq_en_d = avs_writedata[0];
      chk_en_d = avs_writedata[1];
    end
    // A DATA read clears valid/repeat one cycle later.
    rd_clr_d   = avs_read && (avs_address == 2'd0);
    readdata_d = readdata_q;
    if (avs_read) begin
      case (avs_address)
        2'd0:    readdata_d = data_q;
        2'd1:    readdata_d = {28'd0, err_q, ovr_q, rep_q, valid_q};
        2'd2:    readdata_d = {30'd0, chk_en_q, irq_en_q};
        default: readdata_d = {13'd0, state_q, us_cnt_q};
      endcase
    end
    irq_d = irq_en_q & (valid_q | rep_q | err_q);
  end

  // Register file flops.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_q     <= 32'd0;
      valid_q    <= 1'b0;
      rep_q      <= 1'b0;
      ovr_q      <= 1'b0;
      err_q      <= 1'b0;
      seen_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      chk_en_q   <= 1'b0;
      rd_clr_q   <= 1'b0;
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      rep_q      <= rep_d;
      ovr_q      <= ovr_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
      irq_en_q   <= irq_en_d;
      chk_en_q   <= chk_en_d;
      rd_clr_q   <= rd_clr_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign ins_irq      = irq_q;

endmodule

// File: tb/tb_ir_nec_rx_1506.sv
// Bench for ir_nec_rx_1506: a table of register-level scenarios, hand-written corner sequences,
// and randomized frames checked against a behavioural status model.
// Protocol windows are scaled by 40 and the clock is 2 MHz, giving 2 clocks per microsecond.
module tb_ir_nec_rx_1506;

  localparam int unsigned CycUs = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  ir_nec_rx_1506 #(
    .CLK_FREQ_HZ(2000000),
    .TIMEOUT_US (300),
    .TIME_DIV   (40)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .coe_ir_in    (ir),
    .avs_address  (addr),
    .avs_read     (rd),
    .avs_write    (wr),
    .avs_writedata(wdata),
    .avs_readdata (rdata),
    .ins_irq      (irq)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Behavioural model of the visible register state.
  logic [31:0] m_data;
  logic m_valid, m_rep, m_ovr, m_err, m_seen, m_irq_en, m_chk;

  function automatic logic [3:0] m_status();
    return {m_err, m_ovr, m_rep, m_valid};
  endfunction

  function automatic logic m_irq();
    return m_irq_en & (m_valid | m_rep | m_err);
  endfunction

  task automatic m_reset();
    m_data = 0; m_valid = 0; m_rep = 0; m_ovr = 0; m_err = 0; m_seen = 0;
    m_irq_en = 0; m_chk = 0;
  endtask

  task automatic m_frame(input logic [31:0] w);
    logic [7:0] a, na, c, nc;
    a = w[7:0]; na = w[15:8]; c = w[23:16]; nc = w[31:24];
    if (m_chk && ((a != ~na) || (c != ~nc))) begin
      m_err = 1;
    end else begin
      if (m_valid) m_ovr = 1;
      m_data = w; m_valid = 1; m_rep = 0; m_seen = 1;
    end
  endtask

  task automatic m_repeat();
    if (m_valid || m_seen) m_rep = 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic hold(input logic lvl, input int us);
    ir = lvl;
    repeat (us * CycUs) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
  endtask

  // One idle cycle follows each read so a DATA-read clear has landed before the next access.
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
    @(negedge clk);
  endtask

  task automatic write_ctrl(input logic [1:0] v);
    bus_write(2'd2, {30'd0, v});
    m_irq_en = v[0]; m_chk = v[1];
  endtask

  // Sends a frame of nbits data bits. With all 32 bits, it also sends the stop pulse and measures
  // the irq latency in clocks from the final falling edge (-1 if irq stays low).
  task automatic send_frame(input logic [31:0] w, input int nbits, input int glitch_bit,
                            output int lat);
    hold(1'b0, 225);
    hold(1'b1, 112);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, 14);
      if (w[i]) begin
        if (i == glitch_bit) begin
          hold(1'b1, 20); hold(1'b0, 2); hold(1'b1, 20);
        end else begin
          hold(1'b1, 42);
        end
      end else begin
        hold(1'b1, 14);
      end
    end
    lat = -1;
    if (nbits == 32) begin
      ir = 1'b0;
      for (int c = 0; c < 14 * CycUs; c++) begin
        @(negedge clk);
        if (lat < 0 && irq) lat = c + 1;
      end
      hold(1'b1, 20);
    end
  endtask

  task automatic send_repeat();
    hold(1'b0, 225); hold(1'b1, 56); hold(1'b0, 14); hold(1'b1, 20);
  endtask

  typedef enum int {KCtrl, KFrame, KRepeat, KRead, KW1C, KShort} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] arg;
    logic [3:0]  exp_st;
    logic [31:0] exp_data;
    logic        exp_irq;
    logic        chk_lat;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int lat;
    logic [7:0] ra, rc;
    logic [31:0] w;

    tbl[0]  = '{KCtrl,   32'h3,          4'h0, 32'h0,          1'b0, 1'b0};
    tbl[1]  = '{KFrame,  32'hBA45FF00,   4'h1, 32'h0,          1'b1, 1'b1};
    tbl[2]  = '{KRead,   32'h0,          4'h0, 32'hBA45FF00,   1'b0, 1'b0};
    tbl[3]  = '{KRepeat, 32'h0,          4'h2, 32'h0,          1'b1, 1'b0};
    tbl[4]  = '{KRead,   32'h0,          4'h0, 32'hBA45FF00,   1'b0, 1'b0};
    tbl[5]  = '{KFrame,  32'hBB45FF00,   4'h8, 32'h0,          1'b1, 1'b0};
    tbl[6]  = '{KRead,   32'h0,          4'h8, 32'hBA45FF00,   1'b1, 1'b0};
    tbl[7]  = '{KW1C,    32'h8,          4'h0, 32'h0,          1'b0, 1'b0};
    tbl[8]  = '{KCtrl,   32'h1,          4'h0, 32'h0,          1'b0, 1'b0};
    tbl[9]  = '{KFrame,  32'hBB45FF00,   4'h1, 32'h0,          1'b1, 1'b0};
    tbl[10] = '{KFrame,  32'hE11E807F,   4'h5, 32'h0,          1'b1, 1'b0};
    tbl[11] = '{KW1C,    32'h4,          4'h1, 32'h0,          1'b1, 1'b0};
    tbl[12] = '{KRead,   32'h0,          4'h0, 32'hE11E807F,   1'b0, 1'b0};
    tbl[13] = '{KShort,  32'h0,          4'h0, 32'h0,          1'b0, 1'b0};

    m_reset();
    repeat (4) @(negedge clk);
    check("reset_readdata", rdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(2'd1, d); check("reset_status", d, 32'h0);
    bus_read(2'd2, d); check("reset_ctrl", d, 32'h0);
    bus_read(2'd0, d); check("reset_data", d, 32'h0);
    bus_read(2'd3, d); check("reset_fsm", {29'd0, d[18:16]}, 32'h0);

    // Table-driven register scenarios.
    for (int i = 0; i < 14; i++) begin
      case (tbl[i].kind)
        KCtrl:   write_ctrl(tbl[i].arg[1:0]);
        KFrame: begin
          send_frame(tbl[i].arg, 32, -1, lat);
          m_frame(tbl[i].arg);
          if (tbl[i].chk_lat) begin
            // Three filter samples plus the decode, status and irq register stages.
            check("irq_latency", {31'd0, (lat >= 1) && (lat <= 3 * CycUs + 5)}, 32'h1);
          end
        end
        KRepeat: begin send_repeat(); m_repeat(); end
        KRead: begin
          bus_read(2'd0, d);
          check($sformatf("tbl%0d_data", i), d, tbl[i].exp_data);
          m_valid = 0; m_rep = 0;
        end
        KW1C: begin
          bus_write(2'd1, tbl[i].arg);
          m_valid &= ~tbl[i].arg[0]; m_rep &= ~tbl[i].arg[1];
          m_ovr &= ~tbl[i].arg[2]; m_err &= ~tbl[i].arg[3];
        end
        default: begin
          hold(1'b0, 175); hold(1'b1, 112); hold(1'b0, 14); hold(1'b1, 20);
        end
      endcase
      bus_read(2'd1, d);
      check($sformatf("tbl%0d_status", i), d, {28'd0, tbl[i].exp_st});
      check($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
    end

    // A 2 us glitch inside a bit-high period is filtered out.
    write_ctrl(2'd3);
    send_frame(32'hBA45FF00, 32, 8, lat);
    m_frame(32'hBA45FF00);
    bus_read(2'd1, d); check("glitch_status", d, 32'h1);
    bus_read(2'd0, d); check("glitch_data", d, 32'hBA45FF00);
    m_valid = 0; m_rep = 0;

    // Line held low past the timeout drops back to idle without flags.
    hold(1'b0, 100);
    bus_read(2'd3, d); check("long_low_fsm_leadl", {29'd0, d[18:16]}, 32'h1);
    hold(1'b0, 225);
    bus_read(2'd3, d); check("long_low_fsm_idle", {29'd0, d[18:16]}, 32'h0);
    hold(1'b1, 20);
    bus_read(2'd1, d); check("long_low_status", d, 32'h0);

    // Randomized frames, repeats, clears and control settings against the model.
    for (int n = 0; n < 4; n++) begin
      write_ctrl(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        d = {28'd0, 4'($urandom_range(0, 15))};
        bus_write(2'd1, d);
        m_valid &= ~d[0]; m_rep &= ~d[1]; m_ovr &= ~d[2]; m_err &= ~d[3];
      end
      if ($urandom_range(0, 3) == 0) begin
        send_repeat();
        m_repeat();
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          ra = 8'($urandom); rc = 8'($urandom);
          w = {~rc, rc, ~ra, ra};
        end else begin
          w = $urandom;
        end
        send_frame(w, 32, -1, lat);
        m_frame(w);
      end
      bus_read(2'd1, d);
      check($sformatf("rand%0d_status", n), d, {28'd0, m_status()});
      check($sformatf("rand%0d_irq", n), {31'd0, irq}, {31'd0, m_irq()});
      if ($urandom_range(0, 1) == 1) begin
        bus_read(2'd0, d);
        check($sformatf("rand%0d_data", n), d, m_data);
        m_valid = 0; m_rep = 0;
      end
    end

    // Reset in the middle of a frame discards it; the next frame decodes normally.
    write_ctrl(2'd3);
    send_frame(32'h5AA5C33C, 32, -1, lat);
    m_frame(32'h5AA5C33C);
    bus_read(2'd1, d);
    check("pre_reset_status", d, {28'd0, m_status()});
    send_frame(32'hFF0010EF, 17, -1, lat);
    hold(1'b0, 7);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_readdata", rdata, 32'h0);
    check("midreset_irq", {31'd0, irq}, 32'h0);
    ir = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (20) @(negedge clk);
    bus_read(2'd1, d); check("post_reset_status", d, 32'h0);
    bus_read(2'd2, d); check("post_reset_ctrl", d, 32'h0);
    bus_read(2'd0, d); check("post_reset_data", d, 32'h0);
    send_repeat();
    bus_read(2'd1, d); check("repeat_no_frame_status", d, 32'h0);
    write_ctrl(2'd3);
    send_frame(32'hFF0010EF, 32, -1, lat);
    bus_read(2'd1, d); check("after_reset_status", d, 32'h1);
    check("after_reset_irq", {31'd0, irq}, 32'h1);
    bus_read(2'd0, d); check("after_reset_data", d, 32'hFF0010EF);
    bus_read(2'd1, d); check("after_read_status", d, 32'h0);
    check("after_read_irq", {31'd0, irq}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
